// File: rtl/cavlc_pkg.sv
// Shared types and default widths for the CAVLC bitstream packer.
package cavlc_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      TAIL  = 2'd2,
      DONE  = 2'd3
   } packer_state_t;

   localparam int PACK_WORD_W = 32;
   localparam int PACK_IN_W   = 128;
   localparam int PACK_LEN_W  = 7;
   localparam int PACK_CNT_W  = 32;

   // Width needed to count the staging buffer occupancy.
   function automatic int pack_fill_w(input int in_w, input int word_w);
      return $clog2(in_w + word_w);
   endfunction

endpackage

// File: rtl/cavlc_bs_aligner.sv
// Masks an MSB-aligned code to its length and positions it behind the
// bits already held in the packer buffer.
module cavlc_bs_aligner
   import cavlc_pkg::*;
#(
   parameter int IN_W   = PACK_IN_W,
   parameter int WORD_W = PACK_WORD_W,
   parameter int LEN_W  = PACK_LEN_W,
   parameter int FILL_W = pack_fill_w(PACK_IN_W, PACK_WORD_W)
) (
   input  logic [IN_W-1:0]        in_code,
   input  logic [LEN_W-1:0]       in_len,
   input  logic [FILL_W-1:0]      fill,
   output logic [IN_W+WORD_W-1:0] field
);

   logic [IN_W-1:0] len_mask;
   logic [IN_W-1:0] masked;

   always_comb begin
      // Top in_len bits set; in_len == 0 yields an all-zero mask.
      len_mask = ~({IN_W{1'b1}} >> in_len);
      masked   = in_code & len_mask;
      field    = {masked, {WORD_W{1'b0}}} >> fill;
   end

endmodule

// File: rtl/cavlc_bitstream_packer.sv
// Concatenates variable-length CAVLC codes into 32-bit words with flush/pad.
// Optional build macro CAVLC_PACKER_STOP_BIT_EN appends rbsp_stop_one_bit on flush.
module cavlc_bitstream_packer
   import cavlc_pkg::*;
#(
   parameter int WORD_W = PACK_WORD_W,
   parameter int IN_W   = PACK_IN_W,
   parameter int LEN_W  = PACK_LEN_W,
   parameter int CNT_W  = PACK_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [IN_W-1:0]   in_code,
   input  logic [LEN_W-1:0]  in_len,
   output logic              in_ready,
   input  logic              flush_req,
   output logic [WORD_W-1:0] out_word,
   output logic              out_valid,
   output logic              out_last,
   input  logic              out_ready,
   output logic              flush_done,
   output logic [CNT_W-1:0]  bits_total
);

   localparam int BUF_W  = IN_W + WORD_W;
   localparam int FILL_W = pack_fill_w(IN_W, WORD_W);
   localparam logic [FILL_W-1:0] WORD_F = FILL_W'(WORD_W);
   localparam logic [FILL_W-1:0] ONE_F  = FILL_W'(1);

   packer_state_t      state_q, state_d;
   logic [BUF_W-1:0]   buf_q, buf_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [CNT_W-1:0]   total_q, total_d;

   logic [BUF_W-1:0]   field;
   logic [BUF_W-1:0]   stop_vec;
   logic               full;
   logic               accept;
   logic               pop;

   cavlc_bs_aligner #(
      .IN_W   (IN_W),
      .WORD_W (WORD_W),
      .LEN_W  (LEN_W),
      .FILL_W (FILL_W)
   ) u_aligner (
      .in_code (in_code),
      .in_len  (in_len),
      .fill    (fill_q),
      .field   (field)
   );

   always_comb begin
      full       = (fill_q >= WORD_F);
      in_ready   = (state_q == RUN) && !full;
      out_last   = (state_q == TAIL) && (fill_q != '0);
      out_valid  = full || out_last;
      out_word   = buf_q[BUF_W-1 -: WORD_W];
      flush_done = (state_q == DONE);
      bits_total = total_q;
      accept     = in_valid && in_ready;
      pop        = out_valid && out_ready;
      stop_vec   = {1'b1, {(BUF_W-1){1'b0}}} >> fill_q;

      state_d = state_q;
      buf_d   = buf_q;
      fill_d  = fill_q;
      total_d = total_q;

      // Accept needs fill < WORD_W and a pop needs fill >= WORD_W (or TAIL),
      // so at most one of these two updates fires in a cycle.
      if (accept) begin
         buf_d   = buf_q | field;
         fill_d  = fill_q + FILL_W'(in_len);
         total_d = total_q + CNT_W'(in_len);
      end
      if (pop) begin
         buf_d  = buf_q << WORD_W;
         fill_d = fill_q - WORD_F;
      end

      case (state_q)
         RUN: begin
            if (flush_req) state_d = DRAIN;
         end
         DRAIN: begin
            if (!full) begin
               state_d = TAIL;
`ifdef CAVLC_PACKER_STOP_BIT_EN
               buf_d  = buf_q | stop_vec;
               fill_d = fill_q + ONE_F;
`endif
            end
         end
         TAIL: begin
            // Remaining bits already sit zero-padded below the top word.
            if ((fill_q == '0) || pop) begin
               state_d = DONE;
               buf_d   = '0;
               fill_d  = '0;
            end
         end
         DONE: begin
            state_d = RUN;
            buf_d   = '0;
            fill_d  = '0;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         buf_q   <= '0;
         fill_q  <= '0;
         total_q <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         fill_q  <= fill_d;
         total_q <= total_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && accept) begin
         assert (int'(in_len) < IN_W);
      end
   end

endmodule
